fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 64, PC/address width; INSTR_W, default 32, instruction width; DEPTH, default 4, queue entries (power of 2, at least 2); RESET_PC, default 0, first fetch address.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; asserted when 0.
- imem_req_valid  out  1  fetch request present.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  fetch address.
- imem_rsp_valid  in  1  in-order response; always accepted.
- imem_rsp_data  in  INSTR_W  fetched instruction.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode consumes.
- id_instr  out  INSTR_W  head instruction.
- id_pc  out  ADDR_W  PC of head instruction.
- redirect  in  1  branch taken; flush.
- redirect_pc  in  ADDR_W  branch target.

Function
REQ-004 Request fire = imem_req_valid & imem_req_ready; pop = id_valid & id_ready; push = imem_rsp_valid & (drop_cnt == 0).
REQ-005 imem_req_valid SHALL be 1 iff occupancy + outstanding < DEPTH; this credit rule guarantees a queue slot for every response.
REQ-006 imem_req_addr SHALL equal fetch_pc; fetch_pc SHALL advance by 4 on each fire, wrapping modulo 2^ADDR_W.
REQ-007 outstanding SHALL increment on fire, decrement on any imem_rsp_valid, and stay unchanged on both in one cycle; it never exceeds DEPTH.
REQ-008 Responses arriving while drop_cnt > 0 SHALL be discarded, and drop_cnt SHALL decrement.
REQ-009 The queue SHALL be FIFO: id_valid = occupancy > 0; id_instr = head entry; push and pop in the same cycle keep occupancy constant, including when full.
REQ-010 id_pc SHALL equal out_pc, which advances by 4 on each pop.
REQ-011 Combinational path from imem_rsp_* to id_* SHALL NOT exist; minimum response-to-id_valid latency is 1 cycle.
REQ-012 On redirect, at the next edge:
- queue emptied;
- fetch_pc and out_pc loaded with redirect_pc;
- drop_cnt loaded with the number of requests still unanswered after that edge, i.e. outstanding + fire - rsp_valid;
- outstanding updated per REQ-007.
REQ-013 Redirect SHALL take priority over push/pop in the same cycle. A pop in the redirect cycle is still a valid consumption by decode. A request fired in the redirect cycle uses the old fetch_pc and is dropped.
REQ-014 A redirect while drop_cnt > 0 SHALL reload drop_cnt per REQ-012, superseding the old value.
REQ-015 imem_req_valid SHALL NOT depend combinationally on imem_req_ready or redirect.

Reset
REQ-016 While reset = 0, and held until the first clk edge with reset = 1:
- imem_req_valid = 0, id_valid = 0;
- fetch_pc = out_pc = RESET_PC;
- occupancy = outstanding = drop_cnt = 0;
- id_instr = 0.
REQ-017 Reset asserted mid-operation SHALL abandon all state immediately. The environment guarantees memory discards in-flight responses across reset.
REQ-018 After reset release, the first request SHALL be presented in the first cycle with address RESET_PC.

Structure
REQ-019 Package fetch_pkg SHALL hold:
- default parameter constants: FETCH_ADDR_W, FETCH_INSTR_W, FETCH_DEPTH, FETCH_RESET_PC;
- the PC increment constant 4;
- the queue entry typedef (instruction word).
REQ-020 The queue SHALL be a separate sub-module fetch_fifo, parametrised by DEPTH and width, with pointers of clog2(DEPTH)+1 bits for the full/empty distinction, a synchronous flush input, and the same asynchronous active-low reset.
REQ-021 Counters outstanding and drop_cnt SHALL be clog2(DEPTH)+1 bits.

Verification
REQ-022 Reset release with mem always ready (1-cycle response) and id_ready=1 -> requests at 0x0, 0x4, 0x8, ...; id_pc sequence 0x0, 0x4, 0x8 with matching instructions; steady 1 instruction per cycle after fill.
REQ-023 id_ready=0, DEPTH=4, mem ready -> exactly 4 requests issued, id_valid=1, imem_req_valid=0 thereafter; raising id_ready for 1 cycle -> exactly one new request (0x10).
REQ-024 3 requests outstanding (0x8, 0xC, 0x10), redirect to 0x100 -> the 3 old responses are discarded; next id_pc = 0x100 with instruction from address 0x100.
REQ-025 Redirect with a fire and a response in the same cycle -> drop_cnt = outstanding+1-1; no stale instruction reaches decode.
REQ-026 Back-to-back redirects to 0x200 then 0x300 with responses in flight -> only 0x300 stream delivered.
REQ-027 Assert reset mid-stream with queue full -> id_valid=0 and imem_req_valid=0 immediately; after release, first request is at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 64;
  localparam int unsigned FETCH_INSTR_W = 32;
  localparam int unsigned FETCH_DEPTH   = 4;

  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

  localparam int unsigned FETCH_PC_INC = 4;

  typedef logic [FETCH_INSTR_W-1:0] fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus: instruction-memory request/response, decode hand-off and redirect.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = FETCH_ADDR_W,
  parameter int unsigned INSTR_W = FETCH_INSTR_W
) ();

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output id_valid,
    output id_instr,
    output id_pc,
    input  id_ready,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    output id_ready,
    output redirect,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction queue: power-of-two FIFO with wrap-bit pointers and a synchronous flush.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_d;
  logic [PTR_W-1:0] r_rd_ptr, w_rd_ptr_d;
  logic             w_full;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                   (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
  // Empty queue presents zero so the head word is defined straight out of reset.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[IDX_W-1:0]];

  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    if (i_flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
    end else begin
      if (i_push) w_wr_ptr_d = r_wr_ptr + PTR_W'(1);
      if (i_pop)  w_rd_ptr_d = r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_data;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(i_push && !i_pop && !i_flush && w_full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into a small queue, and redirect flush with stale-response dropping.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter int unsigned       DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);

  localparam int unsigned       CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned       SUM_W  = CNT_W + 1;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(FETCH_PC_INC);

  logic [CNT_W-1:0]   w_occ;
  logic               w_empty;
  logic [INSTR_W-1:0] w_head;
  logic [SUM_W-1:0]   w_in_use;
  logic               w_rsp;
  logic               w_fire;
  logic               w_pop;
  logic               w_push;
  logic               w_dropping;

  logic [ADDR_W-1:0]  r_fetch_pc, w_fetch_pc_d;
  logic [ADDR_W-1:0]  r_out_pc, w_out_pc_d;
  logic [CNT_W-1:0]   r_outstanding, w_outstanding_d;
  logic [CNT_W-1:0]   r_drop_cnt, w_drop_cnt_d;

  // Queue entries plus in-flight requests never exceed DEPTH, so every
  // response is guaranteed a slot.
  assign w_in_use           = SUM_W'(w_occ) + SUM_W'(r_outstanding);
  assign bus.imem_req_valid = reset & (w_in_use < SUM_W'(DEPTH));
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.id_valid       = ~w_empty;
  assign bus.id_instr       = w_head;
  assign bus.id_pc          = r_out_pc;

  assign w_rsp      = bus.imem_rsp_valid;
  assign w_fire     = bus.imem_req_valid & bus.imem_req_ready;
  assign w_pop      = bus.id_valid & bus.id_ready;
  assign w_dropping = (r_drop_cnt != '0);
  assign w_push     = w_rsp & ~w_dropping;

  always_comb begin
    w_outstanding_d = r_outstanding;
    if (w_fire && !w_rsp) begin
      w_outstanding_d = r_outstanding + CNT_W'(1);
    end else if (!w_fire && w_rsp) begin
      w_outstanding_d = r_outstanding - CNT_W'(1);
    end
  end

  // After a redirect every request still unanswered belongs to the old stream.
  always_comb begin
    w_drop_cnt_d = r_drop_cnt;
    if (bus.redirect) begin
      w_drop_cnt_d = w_outstanding_d;
    end else if (w_rsp && w_dropping) begin
      w_drop_cnt_d = r_drop_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_fetch_pc_d = r_fetch_pc;
    w_out_pc_d   = r_out_pc;
    if (bus.redirect) begin
      w_fetch_pc_d = bus.redirect_pc;
      w_out_pc_d   = bus.redirect_pc;
    end else begin
      if (w_fire) w_fetch_pc_d = r_fetch_pc + PC_INC;
      if (w_pop)  w_out_pc_d   = r_out_pc + PC_INC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_out_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_d;
      r_out_pc      <= w_out_pc_d;
      r_outstanding <= w_outstanding_d;
      r_drop_cnt    <= w_drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (bus.redirect),
    .i_push  (w_push),
    .i_data  (bus.imem_rsp_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_occ)
  );

  a_outstanding_bound : assert property (@(posedge clk) disable iff (!reset)
    r_outstanding <= CNT_W'(DEPTH));

  a_rsp_expected : assert property (@(posedge clk) disable iff (!reset)
    !(w_rsp && (r_outstanding == '0)));

endmodule
